mio_arbiter: RTL and testbench

- Two-port arbiter sharing the single data-memory/MIO slave between the CPU data port and a loader/debug port (UART boot loader, DMA).
- Sequences every access as a request/acknowledge transaction towards the slave.
- Drives the CPU's MIO_ready/stall indication.
- Adds a timeout watchdog so a dead peripheral cannot hang the core forever.

---
 rtl/mio_arbiter_pkg.sv | 17 +
 rtl/rr_pick2.sv | 27 ++
 rtl/mio_arbiter.sv | 144 ++++++++++++++
 tb/tb_mio_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_arbiter_pkg.sv
// Shared types and constants for the MIO arbiter.
// Imported by the arbiter top and its picker.
package mio_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  // Fill bit for the read data returned on a timeout abort.
  localparam logic ERR_FILL = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way fixed-priority / round-robin picker.
// grant: 0 = port 0 (CPU), 1 = port 1 (loader).
module rr_pick2 #(
  parameter int CPU_PRIO = 1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  logic both;
  logic only1;

  assign both  = req[0] & req[1];
  assign only1 = req[1] & ~req[0];

  // Ties go to port 0 or to the port not served last.
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      both:    grant = (CPU_PRIO != 0) ? 1'b0 : ~last;
      only1:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mio_arbiter.sv
// CPU / loader arbiter for the shared data-memory slave.
// Req/ack sequencing with a saturating timeout watchdog.
module mio_arbiter
  import mio_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 255,
  parameter int CPU_PRIO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err,
  output logic          owner
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_DATA = {DW{ERR_FILL}};

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] crd_q, crd_d;
  logic [DW-1:0] lrd_q, lrd_d;
  logic          pick;

  rr_pick2 #(
    .CPU_PRIO(CPU_PRIO)
  ) u_pick (
    .req   ({ldr_req, cpu_req}),
    .last  (last_q),
    .grant (pick)
  );

  // Next-state, latch and output decode for IDLE/BUSY/DONE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    lrd_d   = lrd_q;
    mem_req = 1'b0;
    cpu_ack = 1'b0;
    ldr_ack = 1'b0;
    bus_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (cpu_req | ldr_req) begin
          owner_d = pick;
          we_d    = pick ? ldr_we : cpu_we;
          addr_d  = pick ? ldr_addr : cpu_addr;
          wdata_d = pick ? ldr_wdata : cpu_wdata;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mem_req = 1'b1;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (mem_ack) begin
          if (!we_q) begin
            if (owner_q == OWN_LDR) lrd_d = mem_rdata;
            else                    crd_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (cnt_q >= TO_LAST) begin
          bus_err = 1'b1;
          if (owner_q == OWN_LDR) lrd_d = ERR_DATA;
          else                    crd_d = ERR_DATA;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_ack = (owner_q == OWN_CPU);
        ldr_ack = (owner_q == OWN_LDR);
        cnt_d   = 8'd0;
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_CPU;
      last_q  <= OWN_LDR;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      lrd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      lrd_q   <= lrd_d;
    end
  end

  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = crd_q;
  assign ldr_rdata = lrd_q;
  assign owner     = owner_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter: vector table plus
// hand sequences for timeout, tie priority and reset.
module tb_mio_arbiter;

  localparam logic [31:0] CA = 32'h0000_0100;
  localparam logic [31:0] CW = 32'hC0C0_0001;
  localparam logic [31:0] LA = 32'h0000_0200;
  localparam logic [31:0] LW = 32'hA5A5_0002;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] a_crd, a_lrd, a_maddr, a_mwd;
  logic        a_cack, a_stall, a_lack, a_mreq, a_mwe;
  logic        a_err, a_own;
  logic [31:0] b_crd, b_lrd, b_maddr, b_mwd;
  logic        b_cack, b_stall, b_lack, b_mreq, b_mwe;
  logic        b_err, b_own;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mio_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(4), .CPU_PRIO(0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_crd), .cpu_ack(a_cack),
    .cpu_stall(a_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(a_lrd), .ldr_ack(a_lack),
    .mem_req(a_mreq), .mem_we(a_mwe),
    .mem_addr(a_maddr), .mem_wdata(a_mwd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(a_err), .owner(a_own)
  );

  mio_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(4), .CPU_PRIO(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_crd), .cpu_ack(b_cack),
    .cpu_stall(b_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(b_lrd), .ldr_ack(b_lack),
    .mem_req(b_mreq), .mem_we(b_mwe),
    .mem_addr(b_maddr), .mem_wdata(b_mwd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(b_err), .owner(b_own)
  );

  typedef struct {
    logic creq, lreq, mack;
    logic e_mreq, e_mwe, e_cack, e_lack;
    logic e_stall, e_own;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(
    input logic [5:0] ctl,
    input logic [31:0] ad, wd
  );
    vec_t v;
    v.creq = 1'b1; v.lreq = 1'b1; v.mack = 1'b1;
    {v.e_mreq, v.e_mwe, v.e_cack,
     v.e_lack, v.e_stall, v.e_own} = ctl;
    v.e_addr = ad;
    v.e_wdata = wd;
    return v;
  endfunction

  task automatic chk(
    input string name,
    input logic [127:0] act, exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    zero_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // mreq,mwe,cack,lack,stall,own
    tbl[0]  = mk(6'b000010, 32'h0, 32'h0);
    tbl[1]  = mk(6'b110010, CA, CW);
    tbl[2]  = mk(6'b001000, 32'h0, 32'h0);
    tbl[3]  = mk(6'b000010, 32'h0, 32'h0);
    tbl[4]  = mk(6'b110011, LA, LW);
    tbl[5]  = mk(6'b000111, 32'h0, 32'h0);
    tbl[6]  = mk(6'b000011, 32'h0, 32'h0);
    tbl[7]  = mk(6'b110010, CA, CW);
    tbl[8]  = mk(6'b001000, 32'h0, 32'h0);
    tbl[9]  = mk(6'b000010, 32'h0, 32'h0);
    tbl[10] = mk(6'b110011, LA, LW);
    tbl[11] = mk(6'b000111, 32'h0, 32'h0);

    zero_in();
    rst = 1'b0;
    #12;
    chk("reset_outs",
        {a_mreq, a_mwe, a_cack, a_lack, a_stall,
         a_err, a_own, b_mreq},
        8'h00);
    chk("reset_data", {a_crd, a_lrd, a_maddr, a_mwd},
        128'h0);

    // CPU read, slave acks in the third BUSY cycle
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    @(negedge clk);
    chk("rd_c0", {a_mreq, a_stall}, 2'b01);
    cyc();
    @(negedge clk);
    chk("rd_busy", {a_mreq, a_mwe, a_maddr},
        {2'b10, 32'h40});
    cyc();
    cyc();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_c3", {a_cack, a_stall, a_mreq}, 3'b011);
    cyc();
    mem_ack = 0;
    @(negedge clk);
    chk("rd_done", {a_cack, a_stall, a_own, a_mreq},
        4'b1000);
    cyc();
    cpu_req = 0;
    @(negedge clk);
    chk("rd_data", {a_cack, a_crd},
        {1'b0, 32'hDEADBEEF});

    // Round-robin collision of writes, vector table
    do_reset();
    cpu_we = 1; cpu_addr = CA; cpu_wdata = CW;
    ldr_we = 1; ldr_addr = LA; ldr_wdata = LW;
    mem_rdata = 32'h5555_5555;
    for (int i = 0; i < 12; i++) begin
      cpu_req = tbl[i].creq;
      ldr_req = tbl[i].lreq;
      mem_ack = tbl[i].mack;
      @(negedge clk);
      chk($sformatf("rr_vec%0d", i),
          {a_mreq, a_mwe, a_cack, a_lack, a_stall,
           a_own, a_err,
           a_mreq ? a_maddr : 32'h0,
           a_mreq ? a_mwd : 32'h0},
          {tbl[i].e_mreq, tbl[i].e_mwe, tbl[i].e_cack,
           tbl[i].e_lack, tbl[i].e_stall, tbl[i].e_own,
           1'b0, tbl[i].e_addr, tbl[i].e_wdata});
      cyc();
    end
    zero_in();
    @(negedge clk);
    chk("wr_keeps_rdata", {a_crd, a_lrd}, 64'h0);

    // Fixed CPU priority with loader held
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = CA; cpu_wdata = CW;
    ldr_req = 1; ldr_we = 1; ldr_addr = LA; ldr_wdata = LW;
    mem_ack = 1;
    for (int t = 0; t < 2; t++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("prio_busy%0d", t),
          {b_own, b_mreq, b_maddr}, {2'b01, CA});
      cyc();
      @(negedge clk);
      chk($sformatf("prio_done%0d", t),
          {b_cack, b_lack}, 2'b10);
      cyc();
    end
    cpu_req = 0;
    cyc();
    @(negedge clk);
    chk("prio_ldr_busy", {b_own, b_mreq, b_maddr},
        {2'b11, LA});
    cyc();
    @(negedge clk);
    chk("prio_ldr_done", {b_cack, b_lack}, 2'b01);
    cyc();
    zero_in();

    // Loader read that never gets an ack
    do_reset();
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h300;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("to_busy%0d", i),
          {a_mreq, a_err, a_lack},
          {1'b1, (i == 4), 1'b0});
    end
    cyc();
    @(negedge clk);
    chk("to_done", {a_lack, a_err, a_mreq}, 3'b100);
    cyc();
    ldr_req = 0;
    @(negedge clk);
    chk("to_data", {a_mreq, a_lrd},
        {1'b0, 32'hFFFF_FFFF});

    // Ack on the same cycle the watchdog expires
    ldr_req = 1; ldr_addr = 32'h304;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) begin
        mem_ack = 1; mem_rdata = 32'h1234_5678;
      end
      @(negedge clk);
      chk($sformatf("co_busy%0d", i),
          {a_mreq, a_err}, 2'b10);
    end
    cyc();
    mem_ack = 0;
    @(negedge clk);
    chk("co_done", {a_lack, a_err}, 2'b10);
    cyc();
    ldr_req = 0;
    @(negedge clk);
    chk("co_data", a_lrd, 32'h1234_5678);

    // Reset dropped in the middle of a loader access
    do_reset();
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h80;
    cyc();
    @(negedge clk);
    chk("mr_busy", {a_mreq, a_own}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("mr_async",
        {a_mreq, a_cack, a_lack, a_err, a_own, a_lrd},
        37'h0);
    ldr_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h84;
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("mr_regrant", {a_mreq, a_own, a_maddr},
        {2'b10, 32'h84});
    cyc();
    mem_ack = 0;
    @(negedge clk);
    chk("mr_done", {a_cack, a_lack}, 2'b10);
    cyc();
    zero_in();
    @(negedge clk);
    chk("mr_data", a_crd, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
